// File: rtl/quadrature_decoder.sv
// quadrature_decoder
//   Decodes a two-channel quadrature encoder into step strobes for a
//   position counter. Each phase is synchronized with two flops and then
//   debounced. A level is only accepted after it has persisted for
//   FILTER_CYCLES consecutive cycles. Changes in the accepted {A,B} pair
//   are classified as one of three things: a forward step, a reverse step,
//   or an illegal double-bit transition.
//
//   State | meaning
//   INIT  | waiting for both synchronized phases to be stable before loading quadState
//   TRACK | decoding accepted-pair changes into step / error strobes
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   synchronous active-high reset
//   phaseA       in   asynchronous quadrature channel A
//   phaseB       in   asynchronous quadrature channel B
//   clearErrors  in   synchronous clear of errorCount
//   enable       out  one-cycle step strobe
//   direction    out  1 = up, 0 = down; holds between strobes
//   error        out  one-cycle illegal-transition strobe
//   errorCount   out  saturating illegal-transition count
//   quadState    out  accepted {A,B} pair
module quadrature_decoder #(
  parameter int FILTER_CYCLES = 4,
  parameter int ERR_WIDTH     = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 phaseA,
  input  logic                 phaseB,
  input  logic                 clearErrors,
  output logic                 enable,
  output logic                 direction,
  output logic                 error,
  output logic [ERR_WIDTH-1:0] errorCount,
  output logic [1:0]           quadState
);

  // The filter counters accept on the cycle that would bring them to
  // FILTER_CYCLES, so they never need to hold that value themselves.
  localparam logic [7:0] F_LAST = 8'(FILTER_CYCLES - 1);

  typedef enum logic {INIT, TRACK} state_t;

  state_t state, state_n;

  logic sync_a1, sync_a2, sync_b1, sync_b2;
  logic acc_a, acc_b, acc_a_n, acc_b_n;
  logic [7:0] cnt_a, cnt_b, cnt_a_n, cnt_b_n;
  logic [7:0] stab_cnt, stab_cnt_n;
  logic enable_n, direction_n, error_n;
  logic [ERR_WIDTH-1:0] err_cnt_n;
  logic [1:0] quad_n;
  logic [1:0] acc_pair;
  logic [1:0] sync_pair;

  assign acc_pair  = {acc_a, acc_b};
  assign sync_pair = {sync_a2, sync_b2};

  // Successor of a pair in the forward (count-up) Gray sequence.
  function automatic logic [1:0] fwd_next(input logic [1:0] p);
    logic [1:0] r;
    r = 2'b00;
    case (p)
      2'b00: r = 2'b01;
      2'b01: r = 2'b11;
      2'b11: r = 2'b10;
      2'b10: r = 2'b00;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= INIT;
      sync_a1    <= 1'b0;
      sync_a2    <= 1'b0;
      sync_b1    <= 1'b0;
      sync_b2    <= 1'b0;
      acc_a      <= 1'b0;
      acc_b      <= 1'b0;
      cnt_a      <= 8'd0;
      cnt_b      <= 8'd0;
      stab_cnt   <= 8'd0;
      enable     <= 1'b0;
      direction  <= 1'b1;
      error      <= 1'b0;
      errorCount <= '0;
      quadState  <= 2'b00;
    end else begin
      state      <= state_n;
      sync_a1    <= phaseA;
      sync_a2    <= sync_a1;
      sync_b1    <= phaseB;
      sync_b2    <= sync_b1;
      acc_a      <= acc_a_n;
      acc_b      <= acc_b_n;
      cnt_a      <= cnt_a_n;
      cnt_b      <= cnt_b_n;
      stab_cnt   <= stab_cnt_n;
      enable     <= enable_n;
      direction  <= direction_n;
      error      <= error_n;
      errorCount <= err_cnt_n;
      quadState  <= quad_n;
    end
  end

  always_comb begin
    state_n     = state;
    acc_a_n     = acc_a;
    acc_b_n     = acc_b;
    cnt_a_n     = 8'd0;
    cnt_b_n     = 8'd0;
    stab_cnt_n  = stab_cnt;
    enable_n    = 1'b0;
    error_n     = 1'b0;
    direction_n = direction;
    err_cnt_n   = errorCount;
    quad_n      = quadState;

    // Per-channel debounce: count while the synchronized level disagrees
    // with the accepted one; any agreement restarts the count.
    if (sync_a2 != acc_a) begin
      if (cnt_a == F_LAST) acc_a_n = sync_a2;
      else                 cnt_a_n = cnt_a + 8'd1;
    end
    if (sync_b2 != acc_b) begin
      if (cnt_b == F_LAST) acc_b_n = sync_b2;
      else                 cnt_b_n = cnt_b + 8'd1;
    end

    case (state)
      INIT: begin
        // The pair is stable when the next value of sync stage 2
        // (currently in stage 1) matches its present value.
        if ({sync_a1, sync_b1} != sync_pair) begin
          stab_cnt_n = 8'd0;
        end else if (stab_cnt == F_LAST) begin
          // Seed the filters with the loaded pair so TRACK starts with
          // no pending difference and emits no spurious strobe.
          quad_n     = sync_pair;
          acc_a_n    = sync_a2;
          acc_b_n    = sync_b2;
          cnt_a_n    = 8'd0;
          cnt_b_n    = 8'd0;
          stab_cnt_n = 8'd0;
          state_n    = TRACK;
        end else begin
          stab_cnt_n = stab_cnt + 8'd1;
        end
      end
      TRACK: begin
        if (acc_pair != quadState) begin
          quad_n = acc_pair;
          if ((acc_pair ^ quadState) == 2'b11) begin
            error_n = 1'b1;
            if (errorCount != {ERR_WIDTH{1'b1}}) err_cnt_n = errorCount + 1'b1;
          end else begin
            enable_n    = 1'b1;
            direction_n = (fwd_next(quadState) == acc_pair);
          end
        end
      end
      default: state_n = INIT;
    endcase

    if (clearErrors) err_cnt_n = '0;
  end

endmodule

// File: tb/tb_quadrature_decoder.sv
module tb_quadrature_decoder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       phaseA = 1'b0;
  logic       phaseB = 1'b0;
  logic       clearErrors = 1'b0;
  logic       enable, direction, error;
  logic [7:0] errorCount;
  logic [1:0] quadState;

  quadrature_decoder #(.FILTER_CYCLES(4), .ERR_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .phaseA(phaseA), .phaseB(phaseB),
    .clearErrors(clearErrors), .enable(enable), .direction(direction),
    .error(error), .errorCount(errorCount), .quadState(quadState)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Event = {enable, direction, error, quadState, errorCount}
  typedef struct {
    int          due;
    logic [12:0] v;
  } ev_t;
  ev_t sb[$];

  localparam int LAT = 7;

  logic [1:0] m_q   = 2'b00;
  logic       m_dir = 1'b1;
  int         m_ec  = 0;

  function automatic int pos(input logic [1:0] p);
    case (p)
      2'b00: return 0;
      2'b01: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  // Scoreboard side: every strobe pops one expected event.
  always @(negedge clock) begin
    ev_t e;
    if (!reset) begin
      if (enable || error) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", {19'd0, enable, direction, error, quadState, errorCount}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("strobe_cycle", cyc, e.due);
          check("strobe_value", {19'd0, enable, direction, error, quadState, errorCount}, {19'd0, e.v});
        end
      end else if (sb.size() != 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        check("missing_strobe", cyc, e.due);
      end
    end
  end

  // Drive a new pair and push the strobe it must cause. With clr set,
  // clearErrors is raised so it is sampled on the same edge as the strobe.
  task automatic drive(input logic [1:0] p, input int hold, input bit clr = 0);
    logic [1:0] d;
    ev_t e;
    @(negedge clock);
    phaseA = p[1];
    phaseB = p[0];
    d = p ^ m_q;
    e.due = cyc + LAT;
    if (d == 2'b11) begin
      m_ec = clr ? 0 : ((m_ec == 255) ? 255 : m_ec + 1);
      e.v = {1'b0, m_dir, 1'b1, p, 8'(m_ec)};
      sb.push_back(e);
    end else if (d != 2'b00) begin
      m_dir = (((pos(p) - pos(m_q) + 4) % 4) == 1);
      e.v = {1'b1, m_dir, 1'b0, p, 8'(m_ec)};
      sb.push_back(e);
    end
    m_q = p;
    if (clr) begin
      repeat (LAT - 1) @(negedge clock);
      clearErrors = 1'b1;
      @(negedge clock);
      clearErrors = 1'b0;
      repeat (hold - LAT) @(negedge clock);
    end else begin
      repeat (hold - 1) @(negedge clock);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_enable"}, enable, 1'b0);
    check({tag, "_error"}, error, 1'b0);
    check({tag, "_direction"}, direction, 1'b1);
    check({tag, "_errorCount"}, errorCount, 8'd0);
    check({tag, "_quadState"}, quadState, 2'b00);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check("init_quadState", quadState, 2'b00);
    check("init_dir", direction, 1'b1);

    // forward then reverse full cycles
    drive(2'b01, 20); drive(2'b11, 20); drive(2'b10, 20); drive(2'b00, 20);
    check("fwd_quadState", quadState, 2'b00);
    check("fwd_dir", direction, 1'b1);
    drive(2'b10, 20); drive(2'b11, 20); drive(2'b01, 20); drive(2'b00, 20);
    repeat (30) @(negedge clock);
    check("rev_dir_holds", direction, 1'b0);

    // 3-cycle glitch on A must be rejected
    @(negedge clock); phaseA = 1'b1;
    repeat (3) @(negedge clock); phaseA = 1'b0;
    repeat (20) @(negedge clock);
    check("glitch_quadState", quadState, 2'b00);
    check("glitch_dir", direction, 1'b0);

    // back-to-back legal steps one cycle apart
    drive(2'b01, 1); drive(2'b11, 20);
    drive(2'b10, 1); drive(2'b00, 20);
    check("b2b_quadState", quadState, 2'b00);

    // illegal transitions, saturation, clear colliding with increment
    for (int i = 0; i < 300; i++) drive(m_q ^ 2'b11, 20);
    check("sat_errorCount", errorCount, 8'd255);
    drive(m_q ^ 2'b11, 20, 1);
    check("clear_errorCount", errorCount, 8'd0);
    drive(m_q ^ 2'b11, 20);
    check("after_clear_errorCount", errorCount, 8'd1);

    // reset mid-sequence with inputs left at 11
    drive(2'b01, 20);
    @(negedge clock); phaseA = 1'b1; phaseB = 1'b1;
    repeat (3) @(negedge clock);
    sb.delete();
    reset = 1'b1;
    @(negedge clock);
    check_reset_vals("midreset");
    @(negedge clock);
    reset = 1'b0;
    m_q = 2'b11; m_dir = 1'b1; m_ec = 0;
    repeat (30) @(negedge clock);
    check("postreset_quadState", quadState, 2'b11);
    check("postreset_errorCount", errorCount, 8'd0);
    check("postreset_dir", direction, 1'b1);
    check("queue_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
